// File: rtl/if_fetch_buffer_if.sv
// rtl/if_fetch_buffer_if.sv - ROM read port, redirect and decode handshake bundle for if_fetch_buffer
interface if_fetch_buffer_if #(
    parameter int WORD_SIZE    = 32,
    parameter int ADDRESS_SIZE = 16
);
    logic                    IRAM_ENABLE;
    logic [ADDRESS_SIZE-1:0] IRAM_ADDRESS;
    logic [WORD_SIZE-1:0]    IRAM_DATA;
    logic                    IRAM_DATA_READY;
    logic                    redirect_valid;
    logic [ADDRESS_SIZE-1:0] redirect_pc;
    logic                    instr_valid;
    logic [WORD_SIZE-1:0]    instr;
    logic [ADDRESS_SIZE-1:0] instr_pc;
    logic                    instr_ready;
    logic                    fetch_err;

    modport master (
        output IRAM_ENABLE, IRAM_ADDRESS, instr_valid, instr, instr_pc, fetch_err,
        input  IRAM_DATA, IRAM_DATA_READY, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  IRAM_ENABLE, IRAM_ADDRESS, instr_valid, instr, instr_pc, fetch_err,
        output IRAM_DATA, IRAM_DATA_READY, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/if_fetch_buffer.sv
// rtl/if_fetch_buffer.sv - PC owner, ROM fetch FSM and show-ahead {pc,instr} FIFO for decode
module if_fetch_buffer #(
    parameter int WORD_SIZE    = 32,
    parameter int ADDRESS_SIZE = 16,
    parameter int DEPTH        = 4,
    parameter int ADDR_STEP    = 4,
    parameter int RESET_PC     = 0,
    parameter int TIMEOUT      = 16
) (
    input  logic clk,
    input  logic rst,
    if_fetch_buffer_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    logic [1:0]              r_state;
    logic [ADDRESS_SIZE-1:0] r_pc;
    logic [PTR_W:0]          r_wr_ptr;
    logic [PTR_W:0]          r_rd_ptr;
    logic [TO_W-1:0]         r_to_cnt;
    logic                    r_fetch_err;
    logic [WORD_SIZE-1:0]    r_mem_instr [DEPTH];
    logic [ADDRESS_SIZE-1:0] r_mem_pc    [DEPTH];

    logic [PTR_W:0] w_count;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_timeout;
    logic           w_flush;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_count == (PTR_W+1)'(DEPTH));
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    // A word arriving on the redirect edge belongs to the old stream and is dropped.
    assign w_push    = (r_state == ST_REQ) && bus.IRAM_DATA_READY && !bus.redirect_valid;
    assign w_pop     = !w_empty && bus.instr_ready;
    assign w_timeout = (r_state == ST_REQ) && !bus.IRAM_DATA_READY
                       && (r_to_cnt == TO_W'(TIMEOUT - 1));
    assign w_flush   = bus.redirect_valid && (r_state != ST_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pc        <= ADDRESS_SIZE'(RESET_PC);
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_to_cnt    <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;

            if (w_flush)
                r_rd_ptr <= r_wr_ptr;
            else if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;

            if (bus.redirect_valid)
                r_pc <= bus.redirect_pc;
            else if (w_push)
                r_pc <= r_pc + ADDRESS_SIZE'(ADDR_STEP);

            case (r_state)
                ST_IDLE: begin
                    if (!w_full)
                        r_state <= ST_REQ;
                end
                ST_REQ: begin
                    if (bus.redirect_valid || bus.IRAM_DATA_READY) begin
                        r_state  <= ST_GAP;
                        r_to_cnt <= '0;
                    end else if (w_timeout) begin
                        r_state     <= ST_HALT;
                        r_fetch_err <= 1'b1;
                        r_to_cnt    <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    r_state <= w_full ? ST_IDLE : ST_REQ;
                end
                default: r_state <= ST_HALT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr[PTR_W-1:0]] <= bus.IRAM_DATA;
            r_mem_pc[r_wr_ptr[PTR_W-1:0]]    <= r_pc;
        end
    end

    assign bus.IRAM_ENABLE  = (r_state == ST_REQ);
    assign bus.IRAM_ADDRESS = r_pc;
    assign bus.instr_valid  = !w_empty;
    assign bus.instr        = w_empty ? '0 : r_mem_instr[r_rd_ptr[PTR_W-1:0]];
    assign bus.instr_pc     = w_empty ? '0 : r_mem_pc[r_rd_ptr[PTR_W-1:0]];
    assign bus.fetch_err    = r_fetch_err;

    a_no_push_full: assert property (@(posedge clk) disable iff (rst) w_push |-> !w_full);
    a_addr_stable: assert property (@(posedge clk) disable iff (rst)
        (r_state == ST_REQ && $past(r_state == ST_REQ) && !$past(rst)) |-> (r_pc == $past(r_pc)));
    a_data_known: assert property (@(posedge clk) disable iff (rst)
        w_push |-> !$isunknown(bus.IRAM_DATA));
endmodule

// File: tb/tb_if_fetch_buffer.sv
// tb/tb_if_fetch_buffer.sv - directed self-checking bench for if_fetch_buffer with a 1-cycle ROM model
module tb_if_fetch_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    if_fetch_buffer_if #(.WORD_SIZE(32), .ADDRESS_SIZE(16)) bus ();

    if_fetch_buffer #(
        .WORD_SIZE(32), .ADDRESS_SIZE(16), .DEPTH(4),
        .ADDR_STEP(4), .RESET_PC(0), .TIMEOUT(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        rom_stall = 1'b0;
    logic        rom_rdy;
    logic [31:0] rom_data;

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        logic [31:0] idx;
        idx = {18'b0, a[15:2]};
        return 32'h2001_0005 + idx * 32'h0001_0002;
    endfunction

    always @(posedge clk) begin
        if (rst || rom_stall) begin
            rom_rdy <= 1'b0;
        end else if (bus.IRAM_ENABLE && !rom_rdy) begin
            rom_rdy  <= 1'b1;
            rom_data <= rom_word(bus.IRAM_ADDRESS);
        end else begin
            rom_rdy <= 1'b0;
        end
    end

    assign bus.IRAM_DATA_READY = rom_rdy;
    assign bus.IRAM_DATA       = rom_rdy ? rom_data : 32'h0;

    logic [15:0] acc_pc [$];
    logic [31:0] acc_in [$];
    logic [15:0] fet_ad [$];
    logic        prev_en = 1'b0;

    always @(posedge clk) begin
        if (!rst && bus.instr_valid && bus.instr_ready) begin
            acc_pc.push_back(bus.instr_pc);
            acc_in.push_back(bus.instr);
        end
    end

    always @(negedge clk) begin
        if (bus.IRAM_ENABLE && !prev_en)
            fet_ad.push_back(bus.IRAM_ADDRESS);
        prev_en = bus.IRAM_ENABLE;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        repeat (3) tick();
        acc_pc.delete();
        acc_in.delete();
        fet_ad.delete();
    endtask

    task automatic wait_en(input logic lvl);
        int n;
        n = 0;
        while (bus.IRAM_ENABLE !== lvl && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) check("wait_enable_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_req(input logic [15:0] addr, input logic need_rdy);
        int n;
        n = 0;
        while (!(bus.IRAM_ENABLE && bus.IRAM_ADDRESS == addr && rom_rdy == need_rdy) && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) check("wait_req_timeout", 64'd0, 64'd1);
    endtask

    localparam logic [8:0] EXP_EN  = 9'b011_011_011;
    localparam logic [8:0] EXP_VAL = 9'b100_100_100;

    initial begin
        logic [8:0]  exp_en;
        logic [8:0]  exp_val;
        logic [15:0] exp_pc [3];
        logic [31:0] exp_in [3];
        int          vk;
        int          n8;

        exp_en  = EXP_EN;
        exp_val = EXP_VAL;
        exp_pc[0] = 16'h0000; exp_pc[1] = 16'h0004; exp_pc[2] = 16'h0008;
        exp_in[0] = 32'h2001_0005; exp_in[1] = 32'h2002_0007; exp_in[2] = 32'h2003_0009;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0;
        bus.instr_ready    = 1'b1;

        // 1: reset state and steady 1-per-3-cycle stream
        do_reset();
        check("rst_enable",   bus.IRAM_ENABLE,  0);
        check("rst_address",  bus.IRAM_ADDRESS, 0);
        check("rst_valid",    bus.instr_valid,  0);
        check("rst_instr",    bus.instr,        0);
        check("rst_instr_pc", bus.instr_pc,     0);
        check("rst_err",      bus.fetch_err,    0);
        rst = 1'b0;
        vk = 0;
        for (int k = 0; k < 9; k++) begin
            tick();
            check($sformatf("t1_en_%0d", k), bus.IRAM_ENABLE, exp_en[k]);
            check($sformatf("t1_val_%0d", k), bus.instr_valid, exp_val[k]);
            if (exp_val[k]) begin
                check($sformatf("t1_pc_%0d", vk), bus.instr_pc, exp_pc[vk]);
                check($sformatf("t1_in_%0d", vk), bus.instr, exp_in[vk]);
                vk++;
            end
        end

        // 2: decode stalled fills FIFO, single pop frees one slot
        bus.instr_ready = 1'b0;
        do_reset();
        rst = 1'b0;
        repeat (30) tick();
        check("t2_fetches", fet_ad.size(), 4);
        check("t2_last_addr", fet_ad.size() == 4 ? fet_ad[3] : 16'hFFFF, 16'h000C);
        check("t2_en_idle", bus.IRAM_ENABLE, 0);
        check("t2_head_pc", bus.instr_pc, 16'h0000);
        check("t2_head_in", bus.instr, 32'h2001_0005);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        repeat (12) tick();
        check("t2_popped_n", acc_pc.size(), 1);
        check("t2_popped_pc", acc_pc.size() > 0 ? acc_pc[0] : 16'hFFFF, 16'h0000);
        check("t2_fetches2", fet_ad.size(), 5);
        check("t2_new_addr", fet_ad.size() == 5 ? fet_ad[4] : 16'hFFFF, 16'h0010);
        check("t2_head_pc2", bus.instr_pc, 16'h0004);
        check("t2_en_idle2", bus.IRAM_ENABLE, 0);

        // 3: redirect while requesting pc 8
        bus.instr_ready = 1'b1;
        do_reset();
        rst = 1'b0;
        wait_req(16'h0008, 1'b0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0040;
        tick();
        bus.redirect_valid = 1'b0;
        check("t3_en_drop", bus.IRAM_ENABLE, 0);
        check("t3_valid", bus.instr_valid, 0);
        wait_en(1'b1);
        check("t3_addr", bus.IRAM_ADDRESS, 16'h0040);
        repeat (10) tick();
        n8 = 0;
        foreach (acc_pc[i]) if (acc_pc[i] == 16'h0008) n8++;
        check("t3_no_pc8", n8, 0);
        check("t3_acc_pc", acc_pc.size() > 2 ? acc_pc[2] : 16'hFFFF, 16'h0040);
        check("t3_acc_in", acc_in.size() > 2 ? acc_in[2] : 32'h0, 32'h2011_0025);

        // 4: redirect on the capture edge drops the word
        do_reset();
        rst = 1'b0;
        wait_req(16'h0004, 1'b1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0080;
        tick();
        bus.redirect_valid = 1'b0;
        check("t4_valid", bus.instr_valid, 0);
        check("t4_en", bus.IRAM_ENABLE, 0);
        repeat (10) tick();
        check("t4_acc0", acc_pc.size() > 0 ? acc_pc[0] : 16'hFFFF, 16'h0000);
        check("t4_acc1", acc_pc.size() > 1 ? acc_pc[1] : 16'hFFFF, 16'h0080);
        check("t4_acc1_in", acc_in.size() > 1 ? acc_in[1] : 32'h0, 32'h2021_0045);

        // 5: ROM never answers -> timeout, HALT, reset recovers
        rom_stall = 1'b1;
        do_reset();
        rst = 1'b0;
        repeat (16) tick();
        check("t5_en_16", bus.IRAM_ENABLE, 1);
        check("t5_err_16", bus.fetch_err, 0);
        tick();
        check("t5_err_17", bus.fetch_err, 1);
        check("t5_en_17", bus.IRAM_ENABLE, 0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0100;
        tick();
        bus.redirect_valid = 1'b0;
        repeat (8) tick();
        check("t5_halt_en", bus.IRAM_ENABLE, 0);
        check("t5_halt_err", bus.fetch_err, 1);
        check("t5_halt_addr", bus.IRAM_ADDRESS, 16'h0100);
        rom_stall = 1'b0;
        do_reset();
        check("t5_rst_err", bus.fetch_err, 0);
        check("t5_rst_addr", bus.IRAM_ADDRESS, 16'h0000);

        // 6: PC wrap, then reset mid-request
        rst = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'hFFFC;
        tick();
        bus.redirect_valid = 1'b0;
        check("t6_en", bus.IRAM_ENABLE, 1);
        check("t6_addr", bus.IRAM_ADDRESS, 16'hFFFC);
        wait_en(1'b0);
        wait_en(1'b1);
        check("t6_wrap_addr", bus.IRAM_ADDRESS, 16'h0000);
        wait_req(16'h0004, 1'b0);
        rst = 1'b1;
        tick();
        check("t6_rst_en", bus.IRAM_ENABLE, 0);
        rst = 1'b0;
        wait_en(1'b1);
        check("t6_restart", bus.IRAM_ADDRESS, 16'h0000);
        check("t6_acc_pc", acc_pc.size() > 0 ? acc_pc[0] : 16'h1234, 16'hFFFC);
        check("t6_acc_in", acc_in.size() > 0 ? acc_in[0] : 32'h0, 32'h6000_8003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
